div_hilo_ctrl: RTL and testbench
================================

# div_hilo_ctrl

Sequencing controller between the CPU decode/execute stage and the iterative signed divider (`DIV`). It accepts DIV instructions, registers the operands, and holds the divider's `start` for the whole operation. When the divider signals `ready`, it captures `z = {remainder, quotient}` into the architectural HI/LO registers and holds the pipeline stalled while a division is in flight. It also owns MTHI/MTLO writes, divide-by-zero handling, cancellation on exception, and a timeout watchdog.

## Interface
- `TIMEOUT`, default 40: cycles in RUN without `div_ready` before the watchdog fires.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; the only reset.
- `div_req` in 1: decode presents a DIV instruction this cycle.
- `rs_data` in 32: dividend (signed).
- `rt_data` in 32: divisor (signed).
- `kill` in 1: exception or flush; cancels any in-flight or requesting divide.
- `mthi_we` in 1: write `rs_data` to HI.
- `mtlo_we` in 1: write `rs_data` to LO.
- `div_dividend` out 32: registered operand to the divider.
- `div_divisor` out 32: registered operand to the divider.
- `div_start` out 1: registered; held high for the entire operation.
- `div_busy` in 1: from the divider; used only for watchdog qualification.
- `div_ready` in 1: from the divider.
- `div_z` in 64: from the divider; `[63:32]` is the remainder, `[31:0]` is the quotient.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.
- `stall` out 1: combinational; freezes the upstream pipeline.
- `div_timeout` out 1: sticky error flag, cleared only by `reset`.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **Reset values:** state=IDLE, `hi`=0, `lo`=0, `div_start`=0, `div_dividend`=0, `div_divisor`=0, `div_timeout`=0, watchdog counter=0.
- **IDLE with `div_req`=1, `kill`=0, `rt_data`≠0:**
  - Latch `rs_data` and `rt_data` into `div_dividend` and `div_divisor`.
  - Set `div_start`=1 and go to RUN.
- **IDLE with `div_req`=1, `kill`=0, `rt_data`=0 (divide-by-zero):**
  - Do not start the divider.
  - On the same edge, write HI=`rs_data` and LO=32'hFFFF_FFFF.
  - Stay in IDLE.
- **RUN:**
  - Watchdog counter increments each cycle.
  - On `div_ready`=1: HI←`div_z[63:32]`, LO←`div_z[31:0]`, `div_start`←0, go to DRAIN.
- **DRAIN:** one cycle with `div_start` low so the divider clears its state. Then go to IDLE.
- **`kill`=1 in RUN:** `div_start`←0, go to DRAIN, HI/LO unchanged.
- **`kill`=1 in IDLE:** `div_req` is ignored.
- **`kill` and `div_ready` in the same cycle:** `kill` wins; no HI/LO write.
- **MTHI/MTLO:**
  - Applied only in IDLE, and only when no divide-by-zero write occurs on the same edge.
  - If a divide-by-zero write and `mthi_we`/`mtlo_we` coincide, the divide-by-zero write wins.
  - `mthi_we`/`mtlo_we` in RUN or DRAIN are ignored.
- **Watchdog:**
  - When the counter reaches `TIMEOUT` in RUN: set `div_timeout`=1, `div_start`←0, go to DRAIN, HI/LO unchanged.
  - The counter clears on entry to RUN.
- **`stall`** = (state==RUN) | (state==DRAIN) | (state==IDLE & `div_req` & ~`kill` & `rt_data`≠0).
- **`hi`/`lo`** are direct register outputs. No bypass: a value written on edge E is visible after E.

## Timing
- Divide accepted at edge T.
- Divider sees `start` at T+1 and loads.
- Iterations run T+2..T+33; correction at T+34; `div_ready` is high after T+34.
- HI/LO are written at edge T+35 and state becomes DRAIN.
- State returns to IDLE at T+36.
- `stall` is high from the acceptance cycle through the DRAIN cycle, which is 37 cycles total.
- A back-to-back DIV is accepted at the earliest at T+37. `div_start` is low for 2 edges between operations.
- Divide-by-zero completes in the acceptance cycle: 0 stall cycles, result visible the next cycle.
- `reset` mid-operation: all state returns to reset values at that edge, and `div_start` drops. The divider self-clears because `start` is low.

## Test plan
- **Signed divide:** `rs`=-7, `rt`=2 → after 37 stall cycles, LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
- **Divide-by-zero and MT:**
  - `rs`=0x1234, `rt`=0 → no stall, next cycle HI=0x1234, LO=0xFFFF_FFFF, `div_start` never rises.
  - `mthi_we` in the same cycle → HI=0x1234.
- **Back-to-back:**
  - 100/7 then -100/7 → first result HI=2, LO=14.
  - Second result HI=-2, LO=-14.
  - Second acceptance no earlier than T+37; `div_start` is low for ≥1 edge between operations.
- **Kill mid-run:**
  - Preload HI=0xAAAA_AAAA, LO=0x5555_5555 via MTHI/MTLO.
  - Start a divide, assert `kill` at T+20 → DRAIN at T+21, IDLE at T+22, HI/LO unchanged.
  - A new divide afterwards returns correct results.
- **Watchdog:**
  - Tie the divider model's `ready` low → `div_timeout`=1 after `TIMEOUT` RUN cycles, `stall` releases 1 cycle later, HI/LO unchanged.
  - `div_timeout` stays set until `reset`.
- **Synchronous reset mid-run:** assert `reset` at T+10 → after that edge `div_start`=0, `hi`=`lo`=0, `stall`=0, state IDLE.

Source files
------------

// File: rtl/div_hilo_if.sv
// Bundle between decode/execute, the iterative divider and the HI/LO controller.
// The controller takes the slave view; the pipeline/divider environment takes the master view.
interface div_hilo_if;
    logic        div_req;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        kill;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_start;
    logic        div_busy;
    logic        div_ready;
    logic [63:0] div_z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        div_timeout;

    modport slave (
        input  div_req, rs_data, rt_data, kill, mthi_we, mtlo_we,
        input  div_busy, div_ready, div_z,
        output div_dividend, div_divisor, div_start, hi, lo, stall, div_timeout
    );

    modport master (
        output div_req, rs_data, rt_data, kill, mthi_we, mtlo_we,
        output div_busy, div_ready, div_z,
        input  div_dividend, div_divisor, div_start, hi, lo, stall, div_timeout
    );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequences DIV through the iterative divider and owns the HI/LO registers.
// 37 stall cycles per divide; divide-by-zero and MTHI/MTLO complete in one edge.
module div_hilo_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic      i_clock,
    input  logic      i_reset,
    div_hilo_if.slave io_bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_dividend;
    logic [31:0]     r_divisor;
    logic            r_start;
    logic            r_timeout;
    logic [CW-1:0]   r_wd_cnt;
    logic            w_rt_zero;
    logic            w_req_ok;
    logic            w_accept;
    logic            w_dz;
    logic            w_done;
    logic            w_wd_fire;
    logic            w_cnt_en;
    logic            w_stall;

    assign w_rt_zero = (io_bus.rt_data == '0);
    assign w_req_ok  = (r_state == S_IDLE) & io_bus.div_req & ~io_bus.kill;
    assign w_accept  = w_req_ok & ~w_rt_zero;
    assign w_dz      = w_req_ok & w_rt_zero;
    // kill has priority over both a result and a watchdog expiry
    assign w_done    = (r_state == S_RUN) & ~io_bus.kill & io_bus.div_ready;
    assign w_wd_fire = (r_state == S_RUN) & ~io_bus.kill & ~io_bus.div_ready
                     & (r_wd_cnt == CW'(TIMEOUT - 1));
    assign w_cnt_en  = (r_state == S_RUN) & (io_bus.div_busy | ~io_bus.div_ready);

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_accept;
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                w_stall = 1'b1;
                if (io_bus.kill | io_bus.div_ready | w_wd_fire) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_stall = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_start    <= 1'b0;
            r_timeout  <= 1'b0;
            r_wd_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // start is simply "we will be in RUN next cycle"
            r_start <= (w_next == S_RUN);
            if (w_accept) begin
                r_dividend <= io_bus.rs_data;
                r_divisor  <= io_bus.rt_data;
            end
            if (w_accept)      r_wd_cnt <= '0;
            else if (w_cnt_en) r_wd_cnt <= r_wd_cnt + CW'(1);
            if (w_wd_fire) r_timeout <= 1'b1;
            if (w_dz) begin
                r_hi <= io_bus.rs_data;
                r_lo <= 32'hFFFF_FFFF;
            end else if (w_done) begin
                r_hi <= io_bus.div_z[63:32];
                r_lo <= io_bus.div_z[31:0];
            end else if (r_state == S_IDLE) begin
                if (io_bus.mthi_we) r_hi <= io_bus.rs_data;
                if (io_bus.mtlo_we) r_lo <= io_bus.rs_data;
            end
        end
    end

    assign io_bus.div_dividend = r_dividend;
    assign io_bus.div_divisor  = r_divisor;
    assign io_bus.div_start    = r_start;
    assign io_bus.hi           = r_hi;
    assign io_bus.lo           = r_lo;
    assign io_bus.stall        = w_stall;
    assign io_bus.div_timeout  = r_timeout;
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: table vectors, hand-written corner sequences and a
// randomized run against a plain-arithmetic HI/LO model, with a behavioural divider.
module tb_div_hilo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_hilo_if bus();

    div_hilo_ctrl #(.TIMEOUT(40)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: loads on the first start edge, ready after 34 start edges.
    logic        tie_low = 1'b0;
    int          dcnt    = 0;
    logic [31:0] da      = 32'd0;
    logic [31:0] db      = 32'd1;
    always @(posedge clk) begin
        if (rst || !bus.div_start) dcnt <= 0;
        else begin
            if (dcnt == 0) begin
                da <= bus.div_dividend;
                db <= bus.div_divisor;
            end
            if (dcnt < 34) dcnt <= dcnt + 1;
        end
    end
    assign bus.div_ready = (dcnt == 34) && !tie_low;
    assign bus.div_busy  = bus.div_start && !bus.div_ready;
    assign bus.div_z     = {32'($signed(da) % $signed(db)), 32'($signed(da) / $signed(db))};

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with stall low; returns at the negedge after acceptance edge T.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b, output int t_acc);
        bus.div_req = 1'b1;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.div_req = 1'b0;
        t_acc = cyc;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input string name, output int t_acc);
        int n;
        int ns;
        bus.div_req = 1'b1;
        bus.rs_data = a;
        bus.rt_data = b;
        #1;
        check({name, " stall_at_req"}, 64'(bus.stall), 64'(b != 32'd0));
        @(negedge clk);
        bus.div_req = 1'b0;
        t_acc = cyc;
        n  = 1;
        ns = 0;
        while (bus.stall && n < 200) begin
            n++;
            if (bus.div_start) ns++;
            @(negedge clk);
        end
        if (b != 32'd0) begin
            check({name, " stall_cycles"}, 64'(n), 64'd37);
            check({name, " start_cycles"}, 64'(ns), 64'd35);
        end else begin
            check({name, " dz_stall_cycles"}, 64'(n), 64'd1);
            check({name, " dz_no_start"}, 64'(bus.div_start), 64'd0);
        end
        check({name, " hi"}, 64'(bus.hi), 64'(e_hi));
        check({name, " lo"}, 64'(bus.lo), 64'(e_lo));
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] v);
        bus.mthi_we = to_hi;
        bus.mtlo_we = !to_hi;
        bus.rs_data = v;
        @(negedge clk);
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        if (to_hi) m_hi = v;
        else       m_lo = v;
    endtask

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int t;
        int t_prev;
        logic [63:0] e;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{32'hFFFF_FFF9, 32'd2,           32'hFFFF_FFFF, 32'hFFFF_FFFD, "neg7_div_2"};
        tbl[1] = '{32'd100,       32'd7,           32'd2,         32'd14,        "b2b_100_div_7"};
        tbl[2] = '{32'hFFFF_FF9C, 32'd7,           32'hFFFF_FFFE, 32'hFFFF_FFF2, "b2b_neg100_div_7"};
        tbl[3] = '{32'h0000_1234, 32'd0,           32'h0000_1234, 32'hFFFF_FFFF, "div_by_zero"};
        tbl[4] = '{32'd7,         32'hFFFF_FFFE,   32'd1,         32'hFFFF_FFFD, "7_div_neg2"};
        tbl[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD,   32'hFFFF_FFFE, 32'd2,         "neg8_div_neg3"};

        bus.div_req = 1'b0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.kill    = 1'b0;
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset hi",       64'(bus.hi), 64'd0);
        check("reset lo",       64'(bus.lo), 64'd0);
        check("reset start",    64'(bus.div_start), 64'd0);
        check("reset dividend", 64'(bus.div_dividend), 64'd0);
        check("reset divisor",  64'(bus.div_divisor), 64'd0);
        check("reset timeout",  64'(bus.div_timeout), 64'd0);
        check("reset stall",    64'(bus.stall), 64'd0);

        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            run_div(tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo, tbl[i].name, t);
            if (i > 0 && tbl[i].rt != 0 && tbl[i-1].rt != 0)
                check({tbl[i].name, " accept_spacing"}, 64'(t - t_prev), 64'd37);
            t_prev = t;
        end

        // divide-by-zero beats simultaneous MTHI/MTLO
        mt(1'b1, 32'h77);
        mt(1'b0, 32'h88);
        bus.div_req = 1'b1; bus.rs_data = 32'h1234; bus.rt_data = 32'd0;
        bus.mthi_we = 1'b1; bus.mtlo_we = 1'b1;
        #1;
        check("dz_mt stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.div_req = 1'b0; bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0;
        check("dz_mt hi",    64'(bus.hi), 64'h1234);
        check("dz_mt lo",    64'(bus.lo), 64'hFFFF_FFFF);
        check("dz_mt start", 64'(bus.div_start), 64'd0);
        m_hi = 32'h1234; m_lo = 32'hFFFF_FFFF;

        // kill in IDLE blocks the request
        bus.div_req = 1'b1; bus.kill = 1'b1; bus.rs_data = 32'd5; bus.rt_data = 32'd1;
        #1;
        check("kill_idle stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.div_req = 1'b0; bus.kill = 1'b0;
        check("kill_idle start", 64'(bus.div_start), 64'd0);
        check("kill_idle hi",    64'(bus.hi), 64'(m_hi));

        // kill mid-run
        mt(1'b1, 32'hAAAA_AAAA);
        mt(1'b0, 32'h5555_5555);
        check("preload hi", 64'(bus.hi), 64'hAAAA_AAAA);
        check("preload lo", 64'(bus.lo), 64'h5555_5555);
        start_div(32'd50, 32'd3, t);
        repeat (20) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_run drain stall", 64'(bus.stall), 64'd1);
        check("kill_run drain start", 64'(bus.div_start), 64'd0);
        @(negedge clk);
        check("kill_run idle stall", 64'(bus.stall), 64'd0);
        check("kill_run hi", 64'(bus.hi), 64'hAAAA_AAAA);
        check("kill_run lo", 64'(bus.lo), 64'h5555_5555);
        run_div(32'd50, 32'd3, 32'd2, 32'd16, "after_kill", t);

        // kill coinciding with ready: no write
        start_div(32'd90, 32'd4, t);
        repeat (34) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_ready hi", 64'(bus.hi), 64'd2);
        check("kill_ready lo", 64'(bus.lo), 64'd16);
        @(negedge clk);
        check("kill_ready idle", 64'(bus.stall), 64'd0);

        // synchronous reset mid-run
        start_div(32'd1000, 32'd3, t);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid start",    64'(bus.div_start), 64'd0);
        check("rst_mid hi",       64'(bus.hi), 64'd0);
        check("rst_mid lo",       64'(bus.lo), 64'd0);
        check("rst_mid stall",    64'(bus.stall), 64'd0);
        check("rst_mid dividend", 64'(bus.div_dividend), 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // watchdog
        mt(1'b1, 32'hCAFE_0001);
        tie_low = 1'b1;
        start_div(32'd9, 32'd2, t);
        repeat (39) @(negedge clk);
        check("wd before flag",  64'(bus.div_timeout), 64'd0);
        check("wd before stall", 64'(bus.stall), 64'd1);
        @(negedge clk);
        check("wd flag",        64'(bus.div_timeout), 64'd1);
        check("wd drain stall", 64'(bus.stall), 64'd1);
        check("wd drain start", 64'(bus.div_start), 64'd0);
        @(negedge clk);
        check("wd release", 64'(bus.stall), 64'd0);
        check("wd hi", 64'(bus.hi), 64'hCAFE_0001);
        check("wd lo", 64'(bus.lo), 64'd0);
        tie_low = 1'b0;
        run_div(32'd9, 32'd2, 32'd1, 32'd4, "after_wd", t);
        check("wd sticky", 64'(bus.div_timeout), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wd cleared", 64'(bus.div_timeout), 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // randomized mix against the HI/LO model
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    a = $urandom;
                    if ($urandom_range(0, 3) == 0)      b = 32'd0;
                    else if ($urandom_range(0, 1) == 1) b = $urandom;
                    else                                b = 32'($urandom_range(1, 20));
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
                    e = ref_div(a, b);
                    run_div(a, b, e[63:32], e[31:0], $sformatf("rand%0d", k), t);
                end
                2: begin
                    mt(1'b1, $urandom);
                    check($sformatf("rand%0d mthi", k), 64'(bus.hi), 64'(m_hi));
                end
                default: begin
                    mt(1'b0, $urandom);
                    check($sformatf("rand%0d mtlo", k), 64'(bus.lo), 64'(m_lo));
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
